lock_arbiter: RTL and testbench
===============================

Name: lock_arbiter

Overview:
- Shares one latched lock resource between N requesters, e.g. ship/enemy units competing for a single shot or sprite slot.
- Uses round-robin arbitration. The winner holds the lock until it releases it or a timeout expires.
- A mandatory cooldown follows every lock before the next grant.
- Sits between the game-logic requesters and the lock-driven datapath: `locked_out` drives that datapath and `grant` tells each requester it owns it.

Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 8: maximum cycles a grant is held. 0 disables the timeout.
- `COOLDOWN`, 2: cycles of forced idle after a lock ends, 1..255.

Ports:
- `pclk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `req`  in  `N_REQ`  level request per requester; held until granted.
- `rel`  in  `N_REQ`  release strobe per requester; only the owner's bit is honoured.
- `grant`  out  `N_REQ`  one-hot grant, registered.
- `owner`  out  `$clog2(N_REQ)`  index of the current/last owner, registered.
- `locked_out`  out  1  high while any grant is active; equals `|grant`, registered.
- `timeout_pulse`  out  1  one-cycle pulse when a lock ends by timeout.

Behaviour:
- **Reset** (`rst`==0 at a `pclk` edge):
  - `state`=IDLE, `grant`=0, `locked_out`=0, `owner`=0, `timeout_pulse`=0, timer=0.
  - RR pointer = `N_REQ`-1, so requester 0 has first priority.
  - Reset mid-lock drops the grant on that edge; no timeout pulse.
- **IDLE:**
  - If `|req`, the winner is the first set bit scanning from (`last_owner`+1) mod `N_REQ` upward with wrap.
  - On that edge: `grant`=onehot(winner), `owner`=winner, `locked_out`=1, timer=0, `state`=LOCKED.
  - Latency: `req` sampled at edge k, `grant` visible from edge k onward (1 cycle).
  - No request: stay in IDLE, all outputs 0 except `owner`, which holds its last value.
- **LOCKED:**
  - Timer increments every cycle.
  - `rel[owner]`=1: on that edge `grant`=0, `locked_out`=0, `state`=COOLDOWN, cooldown timer=0.
  - Else if `TIMEOUT`!=0 and timer==`TIMEOUT`-1: same exit, and `timeout_pulse`=1 for exactly the next cycle.
  - Grant is therefore active for at most `TIMEOUT` cycles.
  - `rel` and timeout on the same edge: treated as a release, no pulse.
  - `rel` bits of non-owners are ignored.
  - The owner dropping `req` does not release the lock; only `rel` does.
  - Requests from others are not queued; they are sampled again in IDLE.
- **COOLDOWN:**
  - Lasts exactly `COOLDOWN` cycles; `grant`=0 throughout.
  - On the edge where cooldown timer==`COOLDOWN`-1, `state`=IDLE.
  - First new grant can occur on the following edge.
  - Release-to-regrant minimum is `COOLDOWN`+1 edges.
- **Fairness:** `last_owner` updates on each grant. A requester holding `req` is served within `N_REQ`-1 other locks.
- **Timer width:** `$clog2(max(TIMEOUT,COOLDOWN)+1)`, saturates-free. Counters clear on every state entry.
- Illegal state encodings return to IDLE with the grant cleared.
- **Invariants:** `grant` is one-hot or zero. `locked_out` == `|grant`. `timeout_pulse` never coincides with `grant`≠0.

Decomposition:
- Shared package `lock_pkg`: state localparams IDLE / LOCKED / COOLDOWN (2-bit), default `TIMEOUT` and `COOLDOWN` constants.
- One sub-module, `rr_pick`: purely combinational round-robin priority picker (`req`, `last_owner` -> `winner`, `valid`). Reusable by other arbiters in the ship logic.
- FSM, timers and output registers live in `lock_arbiter`.

Test Plan:
- **Reset, then single request:** reset low 2 cycles, `req`=0001 held → `grant`=0001, `owner`=0, `locked_out`=1 one edge after `req` sampled. `rel`=0001 pulse at 4th grant cycle → `grant`=0 next edge. Re-grant no earlier than 3 edges later (`COOLDOWN`=2).
- **Round-robin:** `req`=1111 held, each owner releases after 1 cycle → grant sequence 0001, 0010, 0100, 1000, 0001, with 2 idle cooldown cycles between grants.
- **Timeout:** `req`=0100, never release → `grant`=0100 for exactly 8 cycles. `timeout_pulse`=1 on the 9th cycle only, then 2 cooldown cycles.
- **Simultaneous release and timeout:** `rel[owner]` asserted on cycle 8 of the grant → lock ends, `timeout_pulse` stays 0.
- **Foreign release and owner req drop:** owner 1 granted, `rel`=0001 and `req[1]`=0 → `grant` stays 0010 until timeout.
- **Reset mid-lock:** `rst`=0 during LOCKED → `grant`=0, `locked_out`=0 on that edge, no pulse. After reset, `req`=1010 → `grant`=0010 (pointer reset to `N_REQ`-1, so scan starts at 0).

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types and defaults for the lock arbiter and related ship-logic arbiters.
package lock_pkg;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StLocked   = 2'd1,
      StCooldown = 2'd2
   } lock_state_e;

   localparam int unsigned DefaultTimeout  = 8;
   localparam int unsigned DefaultCooldown = 2;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from
// the slot after last_owner, wrapping around.
module rr_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned OW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [OW-1:0]    last_owner,
   output logic [OW-1:0]    winner,
   output logic             valid
);

   int unsigned idx;

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = 0;
      // Distance N_REQ lands back on last_owner, so it has lowest priority.
      for (int unsigned d = 1; d <= N_REQ; d++) begin
         idx = (32'(last_owner) + d) % N_REQ;
         if (!valid && req[idx[OW-1:0]]) begin
            valid  = 1'b1;
            winner = idx[OW-1:0];
         end
      end
   end

endmodule

// File: rtl/lock_arbiter.sv
// Round-robin arbiter for a single latched lock with hold timeout and
// mandatory cooldown between locks.
module lock_arbiter
   import lock_pkg::*;
#(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned TIMEOUT  = DefaultTimeout,
   parameter int unsigned COOLDOWN = DefaultCooldown
) (
   input  logic                     pclk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ-1:0]         rel,
   output logic [N_REQ-1:0]         grant,
   output logic [$clog2(N_REQ)-1:0] owner,
   output logic                     locked_out,
   output logic                     timeout_pulse
);

   localparam int unsigned OW       = $clog2(N_REQ);
   localparam int unsigned TimerMax = max_u(TIMEOUT, COOLDOWN);
   localparam int unsigned TW       = $clog2(TimerMax + 1);

   localparam logic [TW-1:0] ToLast = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic [TW-1:0] CdLast = TW'(COOLDOWN - 1);
   localparam bit            ToEn   = (TIMEOUT != 0);

   lock_state_e      state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [OW-1:0]    owner_q, owner_d;
   logic [OW-1:0]    ptr_q, ptr_d;
   logic             locked_q, locked_d;
   logic             pulse_q, pulse_d;

   logic [OW-1:0]    pick_winner;
   logic             pick_valid;

   rr_pick #(
      .N_REQ (N_REQ),
      .OW    (OW)
   ) u_rr_pick (
      .req        (req),
      .last_owner (ptr_q),
      .winner     (pick_winner),
      .valid      (pick_valid)
   );

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q + 1'b1;
      grant_d  = grant_q;
      owner_d  = owner_q;
      ptr_d    = ptr_q;
      locked_d = locked_q;
      pulse_d  = 1'b0;

      case (state_q)
         StIdle: begin
            grant_d  = '0;
            locked_d = 1'b0;
            timer_d  = '0;
            if (pick_valid) begin
               grant_d  = N_REQ'(1) << pick_winner;
               owner_d  = pick_winner;
               ptr_d    = pick_winner;
               locked_d = 1'b1;
               state_d  = StLocked;
            end
         end

         StLocked: begin
            // Release wins over a coincident timeout, so no pulse in that case.
            if (rel[owner_q]) begin
               grant_d  = '0;
               locked_d = 1'b0;
               timer_d  = '0;
               state_d  = StCooldown;
            end else if (ToEn && (timer_q == ToLast)) begin
               grant_d  = '0;
               locked_d = 1'b0;
               timer_d  = '0;
               pulse_d  = 1'b1;
               state_d  = StCooldown;
            end
         end

         StCooldown: begin
            grant_d  = '0;
            locked_d = 1'b0;
            if (timer_q == CdLast) begin
               timer_d = '0;
               state_d = StIdle;
            end
         end

         default: begin
            grant_d  = '0;
            locked_d = 1'b0;
            timer_d  = '0;
            state_d  = StIdle;
         end
      endcase
   end

   always_ff @(posedge pclk) begin
      if (!rst) begin
         state_q  <= StIdle;
         timer_q  <= '0;
         grant_q  <= '0;
         owner_q  <= '0;
         ptr_q    <= OW'(N_REQ - 1);
         locked_q <= 1'b0;
         pulse_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         grant_q  <= grant_d;
         owner_q  <= owner_d;
         ptr_q    <= ptr_d;
         locked_q <= locked_d;
         pulse_q  <= pulse_d;
      end
   end

   assign grant         = grant_q;
   assign owner         = owner_q;
   assign locked_out    = locked_q;
   assign timeout_pulse = pulse_q;

endmodule

// File: tb/tb_lock_arbiter.sv
// Directed bench for lock_arbiter with a cycle-level reference model and
// literal spot checks.
module tb_lock_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned TO = 8;
   localparam int unsigned CD = 2;

   logic         pclk;
   logic         rst;
   logic [N-1:0] req;
   logic [N-1:0] rel;
   logic [N-1:0] grant;
   logic [1:0]   owner;
   logic         locked_out;
   logic         timeout_pulse;

   int checks   = 0;
   int failures = 0;

   lock_arbiter #(
      .N_REQ    (N),
      .TIMEOUT  (TO),
      .COOLDOWN (CD)
   ) dut (
      .pclk          (pclk),
      .rst           (rst),
      .req           (req),
      .rel           (rel),
      .grant         (grant),
      .owner         (owner),
      .locked_out    (locked_out),
      .timeout_pulse (timeout_pulse)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a lock is "busy" for a number of held cycles; after it ends, the
   // next grant needs more than CD edges of gap.
   bit m_ok    = 1'b0;
   bit m_busy  = 1'b0;
   bit m_pulse = 1'b0;
   int m_owner = 0;
   int m_ptr   = N - 1;
   int m_held  = 0;
   int m_gap   = 1000;

   always @(posedge pclk) begin
      if (!rst) begin
         m_ok    = 1'b1;
         m_busy  = 1'b0;
         m_pulse = 1'b0;
         m_owner = 0;
         m_ptr   = N - 1;
         m_held  = 0;
         m_gap   = 1000;
      end else begin
         m_pulse = 1'b0;
         if (m_busy) begin
            m_held++;
            if (rel[m_owner]) begin
               m_busy = 1'b0;
               m_gap  = 0;
            end else if (TO != 0 && m_held == TO) begin
               m_busy  = 1'b0;
               m_gap   = 0;
               m_pulse = 1'b1;
            end
         end else begin
            if (m_gap < 1000) m_gap++;
            if (m_gap > CD && req != '0) begin
               for (int d = 1; d <= N; d++) begin
                  if (!m_busy && req[(m_ptr + d) % N]) begin
                     m_busy  = 1'b1;
                     m_owner = (m_ptr + d) % N;
                     m_held  = 0;
                  end
               end
               m_ptr = m_owner;
            end
         end
      end
   end

   always @(negedge pclk) begin
      if (m_ok) begin
         check("model_grant", 32'(grant), m_busy ? 32'(1 << m_owner) : 32'd0);
         check("model_owner", 32'(owner), 32'(m_owner));
         check("model_locked", 32'(locked_out), 32'(m_busy));
         check("model_pulse", 32'(timeout_pulse), 32'(m_pulse));
         check("inv_onehot", 32'($onehot0(grant)), 32'd1);
         check("inv_pulse_grant", 32'(timeout_pulse && grant != '0), 32'd0);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge pclk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      req = '0;
      rel = '0;
      tick(1);
      rst = 1'b1;
   endtask

   task automatic wait_grant(output int n);
      n = 0;
      while (grant == '0 && n < 20) begin
         tick(1);
         n++;
      end
   endtask

   task automatic count_hold(output int n);
      n = 1;
      while (n < 30) begin
         tick(1);
         if (grant == '0) break;
         n++;
      end
   endtask

   initial begin
      logic [N-1:0] rr_exp [5];
      int n;
      rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      // Reset, then single request with release and cooldown spacing.
      rst = 1'b0;
      req = '0;
      rel = '0;
      tick(2);
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_owner", 32'(owner), 32'h0);
      check("rst_locked", 32'(locked_out), 32'h0);
      rst = 1'b1;
      req = 4'b0001;
      tick(1);
      check("single_grant", 32'(grant), 32'h1);
      check("single_locked", 32'(locked_out), 32'h1);
      tick(3);
      rel = 4'b0001;
      req = '0;
      tick(1);
      check("single_rel", 32'(grant), 32'h0);
      rel = '0;
      req = 4'b0001;
      tick(1);
      check("cool_1", 32'(grant), 32'h0);
      tick(1);
      check("cool_2", 32'(grant), 32'h0);
      tick(1);
      check("regrant", 32'(grant), 32'h1);
      rel = 4'b0001;
      req = '0;
      tick(1);
      rel = '0;

      // Round-robin over all requesters.
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_grant(n);
         check("rr_grant", 32'(grant), 32'(rr_exp[i]));
         if (i > 0) check("rr_gap", 32'(n), 32'd3);
         rel = grant;
         tick(1);
         rel = '0;
         check("rr_rel", 32'(grant), 32'h0);
      end
      req = '0;

      // Timeout with no release.
      do_reset();
      req = 4'b0100;
      tick(1);
      check("to_grant", 32'(grant), 32'h4);
      req = '0;
      count_hold(n);
      check("to_len", 32'(n), 32'd8);
      check("to_pulse", 32'(timeout_pulse), 32'd1);
      tick(1);
      check("to_pulse_end", 32'(timeout_pulse), 32'd0);

      // Release coinciding with timeout.
      do_reset();
      req = 4'b0001;
      tick(1);
      req = '0;
      tick(7);
      check("sim_held", 32'(grant), 32'h1);
      rel = 4'b0001;
      tick(1);
      rel = '0;
      check("sim_grant", 32'(grant), 32'h0);
      check("sim_pulse", 32'(timeout_pulse), 32'd0);

      // Foreign release and owner dropping req.
      do_reset();
      req = 4'b0010;
      tick(1);
      check("for_grant", 32'(grant), 32'h2);
      check("for_owner", 32'(owner), 32'h1);
      req = '0;
      rel = 4'b0001;
      count_hold(n);
      rel = '0;
      check("for_len", 32'(n), 32'd8);
      check("for_pulse", 32'(timeout_pulse), 32'd1);

      // Reset during a lock.
      do_reset();
      req = 4'b0100;
      tick(1);
      req = '0;
      tick(2);
      rst = 1'b0;
      tick(1);
      check("mid_grant", 32'(grant), 32'h0);
      check("mid_locked", 32'(locked_out), 32'h0);
      check("mid_pulse", 32'(timeout_pulse), 32'h0);
      check("mid_owner", 32'(owner), 32'h0);
      rst = 1'b1;
      req = 4'b1010;
      tick(1);
      check("post_grant", 32'(grant), 32'h2);
      check("post_owner", 32'(owner), 32'h1);
      req = '0;
      rel = 4'b0010;
      tick(1);
      rel = '0;
      tick(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=running required=done");
      $fatal(1, "watchdog");
   end

endmodule
